// File: rtl/counter_sched_pkg.sv
// Shared types and constants for the counter access scheduler.
// Imported by the interface, the arbiter and the top.
package counter_sched_pkg;

    localparam int unsigned NUM_REQ = 2;

    localparam logic OP_READ = 1'b0;
    localparam logic OP_LOAD = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2,
        ST_GAP  = 2'd3
    } state_e;

endpackage

// File: rtl/counter_sched_if.sv
// Requester-side command/response bundle of the counter scheduler.
// Requesters use the master modport; the scheduler uses the slave modport.
interface counter_sched_if;
    import counter_sched_pkg::*;

    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_ready;
    logic [NUM_REQ-1:0] req_op;
    logic [7:0]         req_data0;
    logic [7:0]         req_data1;
    logic [NUM_REQ-1:0] rsp_valid;
    logic [7:0]         rsp_data;

    modport master (
        output req_valid,
        output req_op,
        output req_data0,
        output req_data1,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  req_op,
        input  req_data0,
        input  req_data1,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );

endinterface

// File: rtl/counter_sched_rr_arb2.sv
// Two-way round-robin grant; ptr names the requester favoured on contention.
// No grant at all is issued unless advance is high.
module rr_arb2
    import counter_sched_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               ptr,
    input  logic               advance,
    output logic [NUM_REQ-1:0] gnt
);

    always_comb begin
        gnt = '0;
        if (advance) begin
            if (req == 2'b11) begin
                gnt = ptr ? 2'b10 : 2'b01;
            end else begin
                gnt = req;
            end
        end
    end

endmodule

// File: rtl/counter_sched.sv
// Serialises READ/LOAD commands from two requesters onto one external counter
// with a tri-state output bus; one command in flight at a time.
module counter_sched
    import counter_sched_pkg::*;
#(
    parameter int unsigned TURNAROUND = 1
)
(
    input  logic           clk,
    input  logic           rst,
    counter_sched_if.slave bus,
    output logic           ctr_load_en,
    output logic [7:0]     ctr_load_val,
    output logic           ctr_oe,
    input  logic [7:0]     ctr_bus,
    output logic           busy
);

    localparam logic [1:0] GAP_LAST = (TURNAROUND == 0) ? 2'd0 : 2'(TURNAROUND - 1);

    state_e             state;
    logic               ptr;
    logic               owner;
    logic               op_q;
    logic [7:0]         data_q;
    logic [7:0]         rsp_q;
    logic [1:0]         gap_cnt;
    logic [NUM_REQ-1:0] gnt;
    logic               advance;
    logic               exec_read;
    logic               exec_load;
    logic               rsp_active;

    // Grants are withheld while rst is high so req_ready reads 0 during reset.
    assign advance = (state == ST_IDLE) && !rst;

    rr_arb2 u_arb (
        .req     (bus.req_valid),
        .ptr     (ptr),
        .advance (advance),
        .gnt     (gnt)
    );

    assign bus.req_ready = gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            ptr     <= 1'b0;
            owner   <= 1'b0;
            op_q    <= OP_READ;
            data_q  <= '0;
            rsp_q   <= '0;
            gap_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|gnt) begin
                        owner  <= gnt[1];
                        op_q   <= bus.req_op[gnt[1]];
                        data_q <= gnt[1] ? bus.req_data1 : bus.req_data0;
                        ptr    <= ~gnt[1];
                        state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // The bus is only looked at on a READ; a LOAD echoes its own data.
                    rsp_q <= (op_q == OP_LOAD) ? data_q : ctr_bus;
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    if (TURNAROUND == 0) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= GAP_LAST;
                        state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 2'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign exec_read  = !rst && (state == ST_EXEC) && (op_q == OP_READ);
    assign exec_load  = !rst && (state == ST_EXEC) && (op_q == OP_LOAD);
    assign rsp_active = !rst && (state == ST_RESP);

    assign ctr_oe       = exec_read;
    assign ctr_load_en  = exec_load;
    assign ctr_load_val = exec_load ? data_q : '0;

    assign bus.rsp_valid = rsp_active ? (owner ? 2'b10 : 2'b01) : 2'b00;
    assign bus.rsp_data  = rsp_active ? rsp_q : '0;

    assign busy = !rst && (state != ST_IDLE);

endmodule

// File: tb/tb_counter_sched.sv
// Directed bench for counter_sched: one instance with TURNAROUND=1, one with
// TURNAROUND=0, each driving a free-running loadable counter model.
module tb_counter_sched;
    import counter_sched_pkg::*;

    logic       clk;
    logic       rst;
    logic       crst;

    logic       ld1, oe1, busy1;
    logic [7:0] lv1, cnt1;
    wire  [7:0] cbus1 = oe1 ? cnt1 : 8'hzz;

    logic       ld0, oe0, busy0;
    logic [7:0] lv0, cnt0;
    wire  [7:0] cbus0 = oe0 ? cnt0 : 8'hzz;

    int checks = 0;
    int errors = 0;

    counter_sched_if if1 ();
    counter_sched_if if0 ();

    counter_sched #(.TURNAROUND(1)) dut_t1 (
        .clk          (clk),
        .rst          (rst),
        .bus          (if1),
        .ctr_load_en  (ld1),
        .ctr_load_val (lv1),
        .ctr_oe       (oe1),
        .ctr_bus      (cbus1),
        .busy         (busy1)
    );

    counter_sched #(.TURNAROUND(0)) dut_t0 (
        .clk          (clk),
        .rst          (rst),
        .bus          (if0),
        .ctr_load_en  (ld0),
        .ctr_load_val (lv0),
        .ctr_oe       (oe0),
        .ctr_bus      (cbus0),
        .busy         (busy0)
    );

    // Counter models: increment every cycle, load overrides, own reset.
    always @(posedge clk) begin
        if (crst)     cnt1 <= 8'h00;
        else if (ld1) cnt1 <= lv1;
        else          cnt1 <= cnt1 + 8'd1;
        if (crst)     cnt0 <= 8'h00;
        else if (ld0) cnt0 <= lv0;
        else          cnt0 <= cnt0 + 8'd1;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle1();
        for (int i = 0; i < 10; i++) begin
            if (!busy1) break;
            cyc();
            #1;
        end
        checks++;
        if (busy1 !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle1: busy=%b expected 0 within 10 cycles", busy1);
        end
    endtask

    task automatic wait_idle0();
        for (int i = 0; i < 10; i++) begin
            if (!busy0) break;
            cyc();
            #1;
        end
        checks++;
        if (busy0 !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle0: busy=%b expected 0 within 10 cycles", busy0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        crst = 1'b1;
        if1.req_valid = 2'b11; if1.req_op = 2'b01; if1.req_data0 = 8'h5A; if1.req_data1 = 8'hA5;
        if0.req_valid = 2'b11; if0.req_op = 2'b01; if0.req_data0 = 8'h5A; if0.req_data1 = 8'hA5;
        repeat (2) cyc();
        #1;
        checks++;
        if (if1.req_ready !== 2'b00 || if0.req_ready !== 2'b00) begin
            errors++;
            $display("FAIL reset_ready: got %b/%b expected 00/00", if1.req_ready, if0.req_ready);
        end
        checks++;
        if (if1.rsp_valid !== 2'b00 || if1.rsp_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_rsp: valid=%b data=%h expected 00/00", if1.rsp_valid, if1.rsp_data);
        end
        checks++;
        if (ld1 !== 1'b0 || lv1 !== 8'h00 || oe1 !== 1'b0 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctr: ld=%b val=%h oe=%b busy=%b expected 0/00/0/0", ld1, lv1, oe1, busy1);
        end
        checks++;
        if (ld0 !== 1'b0 || oe0 !== 1'b0 || busy0 !== 1'b0 || if0.rsp_valid !== 2'b00) begin
            errors++;
            $display("FAIL reset_t0: ld=%b oe=%b busy=%b rsp=%b expected 0/0/0/00", ld0, oe0, busy0, if0.rsp_valid);
        end
        if1.req_valid = 2'b00;
        if0.req_valid = 2'b00;
        cyc();
        rst = 1'b0;
        crst = 1'b0;
    endtask

    // r0 LOAD 0x40 while r1 READ waits; r1 is served 4 cycles later and reads 0x43.
    task automatic test_load_then_read();
        cyc();
        if1.req_valid = 2'b11; if1.req_op = 2'b01; if1.req_data0 = 8'h40; if1.req_data1 = 8'h00;
        #1;
        checks++;
        if (if1.req_ready !== 2'b01) begin
            errors++;
            $display("FAIL lr_grant_r0: req_ready=%b expected 01", if1.req_ready);
        end
        cyc();
        if1.req_valid = 2'b10;
        #1;
        checks++;
        if (ld1 !== 1'b1 || lv1 !== 8'h40 || oe1 !== 1'b0 || if1.req_ready !== 2'b00) begin
            errors++;
            $display("FAIL lr_exec_load: ld=%b val=%h oe=%b rdy=%b expected 1/40/0/00", ld1, lv1, oe1, if1.req_ready);
        end
        cyc();
        #1;
        checks++;
        if (if1.rsp_valid !== 2'b01 || if1.rsp_data !== 8'h40 || cnt1 !== 8'h40) begin
            errors++;
            $display("FAIL lr_resp_load: valid=%b data=%h cnt=%h expected 01/40/40", if1.rsp_valid, if1.rsp_data, cnt1);
        end
        cyc();
        #1;
        checks++;
        if (if1.req_ready !== 2'b00 || busy1 !== 1'b1 || if1.rsp_valid !== 2'b00) begin
            errors++;
            $display("FAIL lr_gap: rdy=%b busy=%b rsp=%b expected 00/1/00", if1.req_ready, busy1, if1.rsp_valid);
        end
        cyc();
        #1;
        checks++;
        if (if1.req_ready !== 2'b10 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL lr_grant_r1: rdy=%b busy=%b expected 10/0", if1.req_ready, busy1);
        end
        cyc();
        if1.req_valid = 2'b00;
        #1;
        checks++;
        if (oe1 !== 1'b1 || ld1 !== 1'b0 || cbus1 !== 8'h43) begin
            errors++;
            $display("FAIL lr_exec_read: oe=%b ld=%b bus=%h expected 1/0/43", oe1, ld1, cbus1);
        end
        cyc();
        #1;
        checks++;
        if (if1.rsp_valid !== 2'b10 || if1.rsp_data !== 8'h43) begin
            errors++;
            $display("FAIL lr_resp_read: valid=%b data=%h expected 10/43", if1.rsp_valid, if1.rsp_data);
        end
        wait_idle1();
    endtask

    task automatic test_single_load();
        cyc();
        if1.req_valid = 2'b01; if1.req_op = 2'b01; if1.req_data0 = 8'h40;
        #1;
        checks++;
        if (if1.req_ready !== 2'b01 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL sl_accept: rdy=%b busy=%b expected 01/0", if1.req_ready, busy1);
        end
        cyc();
        if1.req_valid = 2'b00;
        #1;
        checks++;
        if (ld1 !== 1'b1 || lv1 !== 8'h40 || oe1 !== 1'b0 || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL sl_exec: ld=%b val=%h oe=%b busy=%b expected 1/40/0/1", ld1, lv1, oe1, busy1);
        end
        cyc();
        #1;
        checks++;
        if (if1.rsp_valid !== 2'b01 || if1.rsp_data !== 8'h40 || cnt1 !== 8'h40 || ld1 !== 1'b0 || lv1 !== 8'h00) begin
            errors++;
            $display("FAIL sl_resp: valid=%b data=%h cnt=%h ld=%b val=%h expected 01/40/40/0/00",
                     if1.rsp_valid, if1.rsp_data, cnt1, ld1, lv1);
        end
        cyc();
        #1;
        cyc();
        #1;
        checks++;
        if (busy1 !== 1'b0) begin
            errors++;
            $display("FAIL sl_idle: busy=%b expected 0", busy1);
        end
    endtask

    task automatic test_contention();
        logic [1:0] exp_g [4];
        int ngnt;
        bit both_high;
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
        ngnt = 0;
        both_high = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        if1.req_valid = 2'b11; if1.req_op = 2'b00;
        #1;
        for (int i = 0; i < 24 && ngnt < 4; i++) begin
            if (i > 0) begin
                cyc();
                #1;
            end
            if (if1.req_ready == 2'b11) both_high = 1'b1;
            if (if1.req_ready != 2'b00) begin
                checks++;
                if (if1.req_ready !== exp_g[ngnt]) begin
                    errors++;
                    $display("FAIL rr_grant%0d: rdy=%b expected %b", ngnt, if1.req_ready, exp_g[ngnt]);
                end
                ngnt++;
            end
        end
        checks++;
        if (ngnt != 4) begin
            errors++;
            $display("FAIL rr_count: grants=%0d expected 4", ngnt);
        end
        checks++;
        if (both_high) begin
            errors++;
            $display("FAIL rr_onehot: both req_ready bits seen high, expected never");
        end
        cyc();
        if1.req_valid = 2'b00;
        wait_idle1();
    endtask

    // TURNAROUND=0: LOAD 0xFF at c0, READ accepted at c3, EXEC at c4 sees FF+2.
    task automatic test_wrap();
        cyc();
        if0.req_valid = 2'b11; if0.req_op = 2'b01; if0.req_data0 = 8'hFF;
        #1;
        checks++;
        if (if0.req_ready !== 2'b01 || oe0 !== 1'b0) begin
            errors++;
            $display("FAIL wr_accept: rdy=%b oe=%b expected 01/0", if0.req_ready, oe0);
        end
        cyc();
        if0.req_valid = 2'b10;
        #1;
        checks++;
        if (ld0 !== 1'b1 || lv0 !== 8'hFF || oe0 !== 1'b0) begin
            errors++;
            $display("FAIL wr_exec_load: ld=%b val=%h oe=%b expected 1/ff/0", ld0, lv0, oe0);
        end
        cyc();
        #1;
        checks++;
        if (if0.rsp_valid !== 2'b01 || if0.rsp_data !== 8'hFF || oe0 !== 1'b0) begin
            errors++;
            $display("FAIL wr_resp_load: valid=%b data=%h oe=%b expected 01/ff/0", if0.rsp_valid, if0.rsp_data, oe0);
        end
        cyc();
        #1;
        checks++;
        if (if0.req_ready !== 2'b10 || oe0 !== 1'b0 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL wr_grant_read: rdy=%b oe=%b busy=%b expected 10/0/0", if0.req_ready, oe0, busy0);
        end
        cyc();
        if0.req_valid = 2'b00;
        #1;
        checks++;
        if (oe0 !== 1'b1 || cbus0 !== 8'h01) begin
            errors++;
            $display("FAIL wr_exec_read: oe=%b bus=%h expected 1/01", oe0, cbus0);
        end
        cyc();
        #1;
        checks++;
        if (if0.rsp_valid !== 2'b10 || if0.rsp_data !== 8'h01 || $isunknown(if0.rsp_data) || oe0 !== 1'b0) begin
            errors++;
            $display("FAIL wr_resp_read: valid=%b data=%h oe=%b expected 10/01/0", if0.rsp_valid, if0.rsp_data, oe0);
        end
        wait_idle0();
    endtask

    task automatic test_reset_in_exec();
        cyc();
        if1.req_valid = 2'b01; if1.req_op = 2'b00;
        #1;
        checks++;
        if (if1.req_ready !== 2'b01) begin
            errors++;
            $display("FAIL rx_accept: rdy=%b expected 01", if1.req_ready);
        end
        cyc();
        if1.req_valid = 2'b00;
        #1;
        checks++;
        if (oe1 !== 1'b1) begin
            errors++;
            $display("FAIL rx_exec: oe=%b expected 1", oe1);
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        if1.req_valid = 2'b11; if1.req_op = 2'b00;
        #1;
        checks++;
        if (oe1 !== 1'b0 || busy1 !== 1'b0 || if1.rsp_valid !== 2'b00) begin
            errors++;
            $display("FAIL rx_after: oe=%b busy=%b rsp=%b expected 0/0/00", oe1, busy1, if1.rsp_valid);
        end
        checks++;
        if (if1.req_ready !== 2'b01) begin
            errors++;
            $display("FAIL rx_ptr: rdy=%b expected 01", if1.req_ready);
        end
        cyc();
        if1.req_valid = 2'b00;
        #1;
        checks++;
        if (if1.rsp_valid !== 2'b00 || oe1 !== 1'b1) begin
            errors++;
            $display("FAIL rx_new_exec: rsp=%b oe=%b expected 00/1", if1.rsp_valid, oe1);
        end
        wait_idle1();
    endtask

    task automatic test_withdraw();
        cyc();
        if1.req_valid = 2'b01; if1.req_op = 2'b01; if1.req_data0 = 8'h10;
        #1;
        checks++;
        if (if1.req_ready !== 2'b01) begin
            errors++;
            $display("FAIL wd_accept: rdy=%b expected 01", if1.req_ready);
        end
        cyc();
        if1.req_valid = 2'b10; if1.req_op = 2'b00;
        #1;
        checks++;
        if (if1.req_ready !== 2'b00 || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL wd_exec: rdy=%b busy=%b expected 00/1", if1.req_ready, busy1);
        end
        cyc();
        if1.req_valid = 2'b00;
        #1;
        checks++;
        if (if1.rsp_valid !== 2'b01 || if1.rsp_data !== 8'h10) begin
            errors++;
            $display("FAIL wd_resp: valid=%b data=%h expected 01/10", if1.rsp_valid, if1.rsp_data);
        end
        for (int i = 0; i < 3; i++) begin
            cyc();
            #1;
            checks++;
            if (if1.rsp_valid !== 2'b00) begin
                errors++;
                $display("FAIL wd_no_rsp%0d: rsp=%b expected 00", i, if1.rsp_valid);
            end
        end
        checks++;
        if (busy1 !== 1'b0) begin
            errors++;
            $display("FAIL wd_idle: busy=%b expected 0", busy1);
        end
    endtask

    initial begin
        rst = 1'b1;
        crst = 1'b1;
        if1.req_valid = 2'b00; if1.req_op = 2'b00; if1.req_data0 = 8'h00; if1.req_data1 = 8'h00;
        if0.req_valid = 2'b00; if0.req_op = 2'b00; if0.req_data0 = 8'h00; if0.req_data1 = 8'h00;
        test_reset();
        test_load_then_read();
        test_single_load();
        test_contention();
        test_wrap();
        test_reset_in_exec();
        test_withdraw();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
